// File: rtl/ptp_tx_arb_pkg.sv
// ptp_tx_arb shared definitions: FSM encoding and PTP tag field layout.
// Tag = {source id (MSB), per-source sequence number (low bits)}.
package ptp_tx_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TAG  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  function automatic int tag_id_bit(input int w);
    return w - 1;
  endfunction

  function automatic int tag_seq_msb(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/ptp_tx_arb_ts_demux.sv
// TX timestamp return routing by tag source-id bit.
// Optional orphan counter under PTP_TX_ARB_STATS_EN.
module ptp_tx_arb_ts_demux
  import ptp_tx_arb_pkg::*;
#(
  parameter int PTP_TS_WIDTH  = 96,
  parameter int PTP_TAG_WIDTH = 16
) (
`ifdef PTP_TX_ARB_STATS_EN
  input  logic                     clk,
  output logic [15:0]              stat_ts_orphan,
`endif
  input  logic                     rst,
  input  logic [PTP_TS_WIDTH-1:0]  s_axis_tx_ptp_ts_96,
  input  logic [PTP_TAG_WIDTH-1:0] s_axis_tx_ptp_ts_tag,
  input  logic                     s_axis_tx_ptp_ts_valid,
  output logic                     s_axis_tx_ptp_ts_ready,
  output logic [PTP_TS_WIDTH-1:0]  m0_axis_tx_ptp_ts_96,
  output logic [PTP_TAG_WIDTH-2:0] m0_axis_tx_ptp_ts_tag,
  output logic                     m0_axis_tx_ptp_ts_valid,
  input  logic                     m0_axis_tx_ptp_ts_ready,
  output logic [PTP_TS_WIDTH-1:0]  m1_axis_tx_ptp_ts_96,
  output logic [PTP_TAG_WIDTH-2:0] m1_axis_tx_ptp_ts_tag,
  output logic                     m1_axis_tx_ptp_ts_valid,
  input  logic                     m1_axis_tx_ptp_ts_ready
);

  localparam int ID_BIT  = tag_id_bit(PTP_TAG_WIDTH);
  localparam int SEQ_MSB = tag_seq_msb(PTP_TAG_WIDTH);

  logic               id;
  logic [SEQ_MSB:0]   seq_in;

  assign id     = s_axis_tx_ptp_ts_tag[ID_BIT];
  assign seq_in = s_axis_tx_ptp_ts_tag[SEQ_MSB:0];

  assign m0_axis_tx_ptp_ts_96  = s_axis_tx_ptp_ts_96;
  assign m1_axis_tx_ptp_ts_96  = s_axis_tx_ptp_ts_96;
  assign m0_axis_tx_ptp_ts_tag = seq_in;
  assign m1_axis_tx_ptp_ts_tag = seq_in;

  // Outputs are held quiet while reset is asserted.
  assign m0_axis_tx_ptp_ts_valid =
    ~rst & s_axis_tx_ptp_ts_valid & ~id;
  assign m1_axis_tx_ptp_ts_valid =
    ~rst & s_axis_tx_ptp_ts_valid & id;
  assign s_axis_tx_ptp_ts_ready =
    ~rst & (id ? m1_axis_tx_ptp_ts_ready
               : m0_axis_tx_ptp_ts_ready);

`ifdef PTP_TX_ARB_STATS_EN
  logic [SEQ_MSB:0] exp0;
  logic [SEQ_MSB:0] exp1;
  logic             hs0;
  logic             hs1;
  logic             orphan_hit;

  assign hs0 = m0_axis_tx_ptp_ts_valid & m0_axis_tx_ptp_ts_ready;
  assign hs1 = m1_axis_tx_ptp_ts_valid & m1_axis_tx_ptp_ts_ready;
  assign orphan_hit = (hs0 & (seq_in != exp0)) |
                      (hs1 & (seq_in != exp1));

  // Expected sequence resyncs to the returned one so a lost
  // timestamp is counted once, not on every later return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp0           <= '0;
      exp1           <= '0;
      stat_ts_orphan <= '0;
    end else begin
      if (hs0)
        exp0 <= seq_in + 1'b1;
      if (hs1)
        exp1 <= seq_in + 1'b1;
      if (orphan_hit && stat_ts_orphan != 16'hffff)
        stat_ts_orphan <= stat_ts_orphan + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/ptp_tx_arb.sv
// Two-source frame round-robin arbiter for 1G MAC TX with PTP tagging.
// Optional statistics counters under PTP_TX_ARB_STATS_EN.
module ptp_tx_arb
  import ptp_tx_arb_pkg::*;
#(
  parameter int PTP_TS_WIDTH  = 96,
  parameter int PTP_TAG_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s0_axis_tdata,
  input  logic                     s0_axis_tvalid,
  output logic                     s0_axis_tready,
  input  logic                     s0_axis_tlast,
  input  logic                     s0_axis_tuser,
  input  logic [7:0]               s1_axis_tdata,
  input  logic                     s1_axis_tvalid,
  output logic                     s1_axis_tready,
  input  logic                     s1_axis_tlast,
  input  logic                     s1_axis_tuser,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic [PTP_TAG_WIDTH-1:0] m_axis_tx_ptp_ts_tag,
  output logic                     m_axis_tx_ptp_ts_tag_valid,
  input  logic                     m_axis_tx_ptp_ts_tag_ready,
  input  logic [PTP_TS_WIDTH-1:0]  s_axis_tx_ptp_ts_96,
  input  logic [PTP_TAG_WIDTH-1:0] s_axis_tx_ptp_ts_tag,
  input  logic                     s_axis_tx_ptp_ts_valid,
  output logic                     s_axis_tx_ptp_ts_ready,
  output logic [PTP_TS_WIDTH-1:0]  m0_axis_tx_ptp_ts_96,
  output logic [PTP_TAG_WIDTH-2:0] m0_axis_tx_ptp_ts_tag,
  output logic                     m0_axis_tx_ptp_ts_valid,
  input  logic                     m0_axis_tx_ptp_ts_ready,
  output logic [PTP_TS_WIDTH-1:0]  m1_axis_tx_ptp_ts_96,
  output logic [PTP_TAG_WIDTH-2:0] m1_axis_tx_ptp_ts_tag,
  output logic                     m1_axis_tx_ptp_ts_valid,
  input  logic                     m1_axis_tx_ptp_ts_ready,
`ifdef PTP_TX_ARB_STATS_EN
  output logic [31:0]              stat_frames0,
  output logic [31:0]              stat_frames1,
  output logic [15:0]              stat_ts_orphan,
`endif
  output logic [1:0]               grant
);

  localparam int SEQ_W = tag_seq_msb(PTP_TAG_WIDTH) + 1;

  logic [1:0]       state;
  logic             ptr;
  logic [SEQ_W-1:0] seq0;
  logic [SEQ_W-1:0] seq1;
  logic             gid;
  logic             pick;
  logic             beat_hs;
  logic             end_hs;

  assign gid = grant[1];

  // Tie goes to the source that was not granted last.
  assign pick = (s0_axis_tvalid & s1_axis_tvalid) ? ~ptr
                                                  : s1_axis_tvalid;

  assign beat_hs = m_axis_tvalid & m_axis_tready;
  assign end_hs  = beat_hs & m_axis_tlast;

  assign m_axis_tx_ptp_ts_tag_valid = (state == ST_TAG);
  assign m_axis_tx_ptp_ts_tag = {gid, gid ? seq1 : seq0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= 1'b1;
      grant <= 2'b00;
      seq0  <= '0;
      seq1  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (s0_axis_tvalid | s1_axis_tvalid) begin
            state <= ST_TAG;
            grant <= pick ? 2'b10 : 2'b01;
            ptr   <= pick;
          end
        end
        ST_TAG: begin
          if (m_axis_tx_ptp_ts_tag_ready) begin
            state <= ST_XFER;
            if (gid)
              seq1 <= seq1 + 1'b1;
            else
              seq0 <= seq0 + 1'b1;
          end
        end
        ST_XFER: begin
          if (end_hs) begin
            state <= ST_IDLE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Zero-latency pass-through of the owner while in XFER.
  always_comb begin
    m_axis_tdata   = 8'h00;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state == ST_XFER) begin
      if (gid) begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        s1_axis_tready = m_axis_tready;
      end else begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = s0_axis_tuser;
        s0_axis_tready = m_axis_tready;
      end
    end
  end

`ifdef PTP_TX_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames0 <= '0;
      stat_frames1 <= '0;
    end else if (end_hs) begin
      if (gid)
        stat_frames1 <= stat_frames1 + 32'd1;
      else
        stat_frames0 <= stat_frames0 + 32'd1;
    end
  end
`endif

  ptp_tx_arb_ts_demux #(
    .PTP_TS_WIDTH  (PTP_TS_WIDTH),
    .PTP_TAG_WIDTH (PTP_TAG_WIDTH)
  ) u_ts_demux (
`ifdef PTP_TX_ARB_STATS_EN
    .clk                     (clk),
    .stat_ts_orphan          (stat_ts_orphan),
`endif
    .rst                     (rst),
    .s_axis_tx_ptp_ts_96     (s_axis_tx_ptp_ts_96),
    .s_axis_tx_ptp_ts_tag    (s_axis_tx_ptp_ts_tag),
    .s_axis_tx_ptp_ts_valid  (s_axis_tx_ptp_ts_valid),
    .s_axis_tx_ptp_ts_ready  (s_axis_tx_ptp_ts_ready),
    .m0_axis_tx_ptp_ts_96    (m0_axis_tx_ptp_ts_96),
    .m0_axis_tx_ptp_ts_tag   (m0_axis_tx_ptp_ts_tag),
    .m0_axis_tx_ptp_ts_valid (m0_axis_tx_ptp_ts_valid),
    .m0_axis_tx_ptp_ts_ready (m0_axis_tx_ptp_ts_ready),
    .m1_axis_tx_ptp_ts_96    (m1_axis_tx_ptp_ts_96),
    .m1_axis_tx_ptp_ts_tag   (m1_axis_tx_ptp_ts_tag),
    .m1_axis_tx_ptp_ts_valid (m1_axis_tx_ptp_ts_valid),
    .m1_axis_tx_ptp_ts_ready (m1_axis_tx_ptp_ts_ready)
  );

endmodule

// File: tb/tb_ptp_tx_arb.sv
// Scoreboard bench for ptp_tx_arb (16-bit tag DUT plus a 4-bit tag DUT).
// Source drivers feed queues; a monitor pops expected beats and tags.
module tb_ptp_tx_arb;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic clk;
  logic rst;

  logic [7:0]  s0_tdata, s1_tdata, m_tdata;
  logic        s0_tvalid, s0_tready, s0_tlast, s0_tuser;
  logic        s1_tvalid, s1_tready, s1_tlast, s1_tuser;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [15:0] tag;
  logic        tag_valid, tag_ready;
  logic [95:0] s_ts;
  logic [15:0] s_tag;
  logic        s_valid, s_ready;
  logic [95:0] m0_ts, m1_ts;
  logic [14:0] m0_tag, m1_tag;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [1:0]  grant;
`ifdef PTP_TX_ARB_STATS_EN
  logic [31:0] stat_frames0, stat_frames1;
  logic [15:0] stat_ts_orphan;
  logic [31:0] d4_frames0, d4_frames1;
  logic [15:0] d4_orphan;
`endif

  logic [7:0]  d4_s0_tdata, d4_m_tdata;
  logic        d4_s0_tvalid, d4_s0_tready, d4_s0_tlast;
  logic        d4_s1_tready;
  logic        d4_m_tvalid, d4_m_tready, d4_m_tlast, d4_m_tuser;
  logic [3:0]  d4_tag;
  logic        d4_tag_valid, d4_tag_ready;
  logic        d4_s_ready;
  logic [95:0] d4_m0_ts, d4_m1_ts;
  logic [2:0]  d4_m0_tag, d4_m1_tag;
  logic        d4_m0_valid, d4_m1_valid;
  logic [1:0]  d4_grant;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t      src_q0[$];
  beat_t      src_q1[$];
  beat_t      exp_beat_q[$];
  logic [15:0] exp_tag_q[$];
  logic [3:0]  exp4_q[$];

  ptp_tx_arb dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid),
    .s0_axis_tready(s0_tready), .s0_axis_tlast(s0_tlast),
    .s0_axis_tuser(s0_tuser),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid),
    .s1_axis_tready(s1_tready), .s1_axis_tlast(s1_tlast),
    .s1_axis_tuser(s1_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser),
    .m_axis_tx_ptp_ts_tag(tag),
    .m_axis_tx_ptp_ts_tag_valid(tag_valid),
    .m_axis_tx_ptp_ts_tag_ready(tag_ready),
    .s_axis_tx_ptp_ts_96(s_ts), .s_axis_tx_ptp_ts_tag(s_tag),
    .s_axis_tx_ptp_ts_valid(s_valid),
    .s_axis_tx_ptp_ts_ready(s_ready),
    .m0_axis_tx_ptp_ts_96(m0_ts), .m0_axis_tx_ptp_ts_tag(m0_tag),
    .m0_axis_tx_ptp_ts_valid(m0_valid),
    .m0_axis_tx_ptp_ts_ready(m0_ready),
    .m1_axis_tx_ptp_ts_96(m1_ts), .m1_axis_tx_ptp_ts_tag(m1_tag),
    .m1_axis_tx_ptp_ts_valid(m1_valid),
    .m1_axis_tx_ptp_ts_ready(m1_ready),
`ifdef PTP_TX_ARB_STATS_EN
    .stat_frames0(stat_frames0), .stat_frames1(stat_frames1),
    .stat_ts_orphan(stat_ts_orphan),
`endif
    .grant(grant)
  );

  ptp_tx_arb #(.PTP_TS_WIDTH(96), .PTP_TAG_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(d4_s0_tdata), .s0_axis_tvalid(d4_s0_tvalid),
    .s0_axis_tready(d4_s0_tready), .s0_axis_tlast(d4_s0_tlast),
    .s0_axis_tuser(1'b0),
    .s1_axis_tdata(8'h00), .s1_axis_tvalid(1'b0),
    .s1_axis_tready(d4_s1_tready), .s1_axis_tlast(1'b0),
    .s1_axis_tuser(1'b0),
    .m_axis_tdata(d4_m_tdata), .m_axis_tvalid(d4_m_tvalid),
    .m_axis_tready(d4_m_tready), .m_axis_tlast(d4_m_tlast),
    .m_axis_tuser(d4_m_tuser),
    .m_axis_tx_ptp_ts_tag(d4_tag),
    .m_axis_tx_ptp_ts_tag_valid(d4_tag_valid),
    .m_axis_tx_ptp_ts_tag_ready(d4_tag_ready),
    .s_axis_tx_ptp_ts_96(96'h0), .s_axis_tx_ptp_ts_tag(4'h0),
    .s_axis_tx_ptp_ts_valid(1'b0),
    .s_axis_tx_ptp_ts_ready(d4_s_ready),
    .m0_axis_tx_ptp_ts_96(d4_m0_ts),
    .m0_axis_tx_ptp_ts_tag(d4_m0_tag),
    .m0_axis_tx_ptp_ts_valid(d4_m0_valid),
    .m0_axis_tx_ptp_ts_ready(1'b1),
    .m1_axis_tx_ptp_ts_96(d4_m1_ts),
    .m1_axis_tx_ptp_ts_tag(d4_m1_tag),
    .m1_axis_tx_ptp_ts_valid(d4_m1_valid),
    .m1_axis_tx_ptp_ts_ready(1'b1),
`ifdef PTP_TX_ARB_STATS_EN
    .stat_frames0(d4_frames0), .stat_frames1(d4_frames1),
    .stat_ts_orphan(d4_orphan),
`endif
    .grant(d4_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source 0 driver: present queue head, pop on a handshake.
  initial begin
    logic acc;
    s0_tvalid = 1'b0; s0_tdata = 8'h00;
    s0_tlast = 1'b0;  s0_tuser = 1'b0;
    forever begin
      @(negedge clk);
      acc = s0_tvalid && s0_tready;
      @(posedge clk);
      #1;
      if (acc && src_q0.size() > 0) void'(src_q0.pop_front());
      if (src_q0.size() > 0) begin
        s0_tvalid = 1'b1;
        {s0_tdata, s0_tlast, s0_tuser} = src_q0[0];
      end else begin
        s0_tvalid = 1'b0;
      end
    end
  end

  initial begin
    logic acc;
    s1_tvalid = 1'b0; s1_tdata = 8'h00;
    s1_tlast = 1'b0;  s1_tuser = 1'b0;
    forever begin
      @(negedge clk);
      acc = s1_tvalid && s1_tready;
      @(posedge clk);
      #1;
      if (acc && src_q1.size() > 0) void'(src_q1.pop_front());
      if (src_q1.size() > 0) begin
        s1_tvalid = 1'b1;
        {s1_tdata, s1_tlast, s1_tuser} = src_q1[0];
      end else begin
        s1_tvalid = 1'b0;
      end
    end
  end

  // Monitor: every MAC-side beat and tag handshake is scored.
  always @(negedge clk) begin
    beat_t       eb;
    logic [15:0] et;
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        n_checks++;
        if (exp_beat_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected got=%h", m_tdata);
        end else begin
          eb = exp_beat_q.pop_front();
          if ({m_tdata, m_tlast, m_tuser} !== eb) begin
            n_fail++;
            $display("FAIL beat got=%h/%b/%b exp=%h/%b/%b",
              m_tdata, m_tlast, m_tuser, eb.d, eb.l, eb.u);
          end
        end
      end
      if (tag_valid && tag_ready) begin
        n_checks++;
        if (exp_tag_q.size() == 0) begin
          n_fail++;
          $display("FAIL tag_unexpected got=%h", tag);
        end else begin
          et = exp_tag_q.pop_front();
          if (tag !== et) begin
            n_fail++;
            $display("FAIL tag got=%h exp=%h", tag, et);
          end
        end
      end
    end
  end

  function automatic beat_t mk_beat(int n, int i, logic [7:0] base);
    beat_t b;
    b.d = base + 8'(i * 17);
    b.l = (i == n - 1);
    b.u = (i == 0);
    return b;
  endfunction

  task automatic add_frame(input int src, input int n,
                           input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      if (src == 0) src_q0.push_back(mk_beat(n, i, base));
      else          src_q1.push_back(mk_beat(n, i, base));
    end
  endtask

  task automatic expect_frame(input int n, input logic [7:0] base,
                              input logic [15:0] t);
    exp_tag_q.push_back(t);
    for (int i = 0; i < n; i++)
      exp_beat_q.push_back(mk_beat(n, i, base));
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_beat_q.size() + exp_tag_q.size() +
            src_q0.size() + src_q1.size()) != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 400) begin
      n_fail++;
      $display("FAIL %s_timeout got=%0d exp=0 pending", name,
        exp_beat_q.size() + exp_tag_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1; s_tag = 16'h8001;
    m0_ready = 1'b1; m1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({m_tvalid, tag_valid, s0_tready, s1_tready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_valids got=%b exp=0000",
        {m_tvalid, tag_valid, s0_tready, s1_tready});
    end
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_grant got=%b exp=00", grant);
    end
    n_checks++;
    if ({s_ready, m0_valid, m1_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ts_gate got=%b exp=000",
        {s_ready, m0_valid, m1_valid});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, m1_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL release_ts got=%b exp=11", {s_ready, m1_valid});
    end
    s_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({grant, tag_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b exp=000",
        {grant, tag_valid});
    end
  endtask

  task automatic test_single();
    add_frame(0, 3, 8'haa);
    expect_frame(3, 8'haa, 16'h0000);
    drain("single");
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single_grant_idle got=%b exp=00", grant);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    tag_ready = 1'b0;
    add_frame(0, 2, 8'h11);
    expect_frame(2, 8'h11, 16'h0001);
    while (!s0_tvalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ({tag_valid, m_tvalid, s0_tready} !== 3'b100) begin
        n_fail++;
        $display("FAIL bp_hold got=%b exp=100",
          {tag_valid, m_tvalid, s0_tready});
      end
    end
    @(posedge clk);
    #1 tag_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_tvalid, m_tdata} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL bp_first_beat got=%b/%h exp=1/11",
        m_tvalid, m_tdata);
    end
    drain("bp");
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      add_frame(0, 2, 8'h01 + 8'(16 * k));
      add_frame(1, 2, 8'h81 + 8'(16 * k));
      expect_frame(2, 8'h01 + 8'(16 * k), 16'(k));
      expect_frame(2, 8'h81 + 8'(16 * k), 16'h8000 | 16'(k));
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drain("rr");
  endtask

  task automatic test_back_to_back();
    int k = 0;
    add_frame(0, 3, 8'h30);
    add_frame(0, 3, 8'h60);
    expect_frame(3, 8'h30, 16'h0004);
    expect_frame(3, 8'h60, 16'h0005);
    do begin
      @(negedge clk);
      k++;
    end while (!(m_tvalid && m_tready && m_tlast) && k < 50);
    @(negedge clk);
    n_checks++;
    if ({grant, tag_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_idle got=%b exp=000", {grant, tag_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({grant, tag_valid} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_retag got=%b exp=011", {grant, tag_valid});
    end
    drain("b2b");
  endtask

  task automatic test_ts_routing();
    s_ts = 96'h1_0000_0000_0000_0123;
    s_tag = 16'h8005; s_valid = 1'b1;
    m0_ready = 1'b1; m1_ready = 1'b0;
    #1;
    n_checks++;
    if ({m1_valid, m0_valid, s_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL ts_route1 got=%b exp=100",
        {m1_valid, m0_valid, s_ready});
    end
    n_checks++;
    if ({m1_ts, m1_tag} !== {96'h1_0000_0000_0000_0123, 15'h0005}) begin
      n_fail++;
      $display("FAIL ts_data1 got=%h/%h exp=%h/0005",
        m1_ts, m1_tag, 96'h1_0000_0000_0000_0123);
    end
    m1_ready = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ts_ready1 got=%b exp=1", s_ready);
    end
    s_tag = 16'h0003; m0_ready = 1'b0;
    #1;
    n_checks++;
    if ({m0_valid, m1_valid, s_ready, m0_tag} !== {3'b100, 15'h3}) begin
      n_fail++;
      $display("FAIL ts_route0 got=%b%b%b/%h exp=100/0003",
        m0_valid, m1_valid, s_ready, m0_tag);
    end
    s_valid = 1'b0; m0_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_xfer();
    int k = 0;
    add_frame(0, 4, 8'h41);
    expect_frame(4, 8'h41, 16'h0006);
    do begin
      @(negedge clk);
      k++;
    end while (!(m_tvalid && m_tdata == 8'h52) && k < 50);
    #2 rst = 1'b1;
    src_q0.delete();
    exp_beat_q.delete();
    exp_tag_q.delete();
    #1;
    n_checks++;
    if ({m_tvalid, grant} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=000", {m_tvalid, grant});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    add_frame(1, 2, 8'h91);
    expect_frame(2, 8'h91, 16'h8000);
    drain("post_reset1");
    add_frame(0, 1, 8'h5a);
    expect_frame(1, 8'h5a, 16'h0000);
    drain("post_reset0");
  endtask

  task automatic test_wrap();
    logic       done;
    logic [3:0] et;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      d4_s0_tvalid = 1'b1; d4_s0_tdata = 8'(i); d4_s0_tlast = 1'b1;
      exp4_q.push_back(4'(i % 8));
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        if (d4_tag_valid && d4_tag_ready) begin
          et = exp4_q.pop_front();
          n_checks++;
          if (d4_tag !== et) begin
            n_fail++;
            $display("FAIL wrap_tag%0d got=%h exp=%h", i, d4_tag, et);
          end
        end
        if (d4_m_tvalid && d4_m_tready) done = 1'b1;
      end
      n_checks++;
      if (!done || exp4_q.size() != 0) begin
        n_fail++;
        $display("FAIL wrap_frame%0d got=%b exp=1", i, done);
      end
      @(posedge clk);
      #1 d4_s0_tvalid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    m_tready = 1'b1; tag_ready = 1'b1;
    s_ts = '0; s_tag = '0; s_valid = 1'b0;
    m0_ready = 1'b0; m1_ready = 1'b0;
    d4_s0_tdata = 8'h00; d4_s0_tvalid = 1'b0; d4_s0_tlast = 1'b0;
    d4_m_tready = 1'b1; d4_tag_ready = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_back_to_back();
    test_ts_routing();
    test_reset_mid_xfer();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ptp_tx_arb.md
Name: ptp_tx_arb

Overview:
- Frame-level round-robin arbiter that shares the single 1G MAC TX AXI-stream path between two frame sources.
- For every granted frame it issues a PTP timestamp tag to the MAC, built as {source id, per-source sequence number}.
- It steers each returned TX timestamp back to the source that sent the frame.
- Sits between the application frame generators and the MAC's tx_axis / tag / TX-timestamp interfaces. The MAC is built with TX_PTP_TAG_ENABLE=1.

Parameters:
- PTP_TS_WIDTH, 96, width of the timestamp carried on the TX timestamp path.
- PTP_TAG_WIDTH, 16, MAC tag width. MSB is the source id; the low PTP_TAG_WIDTH-1 bits are the sequence number. Minimum 2.

Ports:
- clk  in  1  single clock for the whole block (MAC logic clock)
- rst  in  1  asynchronous, active-high reset
- s0_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  source 0 frame stream
- s1_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  source 1 frame stream
- m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  to MAC tx_axis
- m_axis_tx_ptp_ts_tag  out  PTP_TAG_WIDTH  tag for the granted frame
- m_axis_tx_ptp_ts_tag_valid / _ready  out/in  1/1  tag handshake to MAC
- s_axis_tx_ptp_ts_96  in  PTP_TS_WIDTH  timestamp from MAC
- s_axis_tx_ptp_ts_tag  in  PTP_TAG_WIDTH  tag returned with the timestamp
- s_axis_tx_ptp_ts_valid / _ready  in/out  1/1  timestamp handshake from MAC
- mN_axis_tx_ptp_ts_96  out  PTP_TS_WIDTH  timestamp to source N (N=0,1)
- mN_axis_tx_ptp_ts_tag  out  PTP_TAG_WIDTH-1  sequence number returned to source N
- mN_axis_tx_ptp_ts_valid / _ready  out/in  1/1  handshake to source N
- grant  out  2  one-hot current owner; 0 when idle

Behaviour:
- FSM states:
  - IDLE -> TAG when any sN tvalid is high. The grant is registered in the same edge.
  - TAG -> XFER on the tag handshake.
  - XFER -> IDLE on a handshake with tlast=1.
- Arbitration is round-robin on a 1-bit last-granted pointer.
  - Both sources requesting: grant the source other than last-granted.
  - One source requesting: grant it.
  - The pointer updates when the grant is registered.
- Reset values: state=IDLE, pointer=1 (source 0 wins first tie), grant=0, all tready=0, m_axis_tvalid=0, tag_valid=0, both sequence counters=0.
- TAG state:
  - tag_valid=1; tag={granted id, seq[granted]}.
  - Frame data is blocked: sN_tready=0, m_axis_tvalid=0.
  - seq[granted] increments on the tag handshake and wraps modulo 2^(PTP_TAG_WIDTH-1).
- XFER state:
  - Combinational pass-through of the granted source: m_axis_* = sN_*, sN_tready = m_axis_tready.
  - The non-granted source's tready is 0.
  - Zero added latency per beat.
- Latency: tvalid in IDLE -> tag_valid on the next cycle. First data beat is presentable in the cycle after the tag handshake.
- A source that raises tvalid mid-frame of the other source waits. No preemption.
- A back-to-back frame from the same source, with the other source idle, re-enters TAG after exactly one IDLE cycle.
- Timestamp return path (combinational, independent of the FSM):
  - Route by s_axis_tx_ptp_ts_tag MSB.
  - mN_valid = s_valid & (MSB==N).
  - s_ready = mM_ready, where M is the tag MSB.
  - ts_96 goes to both outputs; mN tag = s tag low bits.
- While rst is high, s_axis_tx_ptp_ts_ready=0 and m0/m1 valid=0.
- Reset asserted mid-frame: the FSM goes to IDLE immediately and m_axis_tvalid drops without tlast. The MAC frame FIFO discards the partial frame; the sources must restart their frames.

Optional Feature:
- Macro: PTP_TX_ARB_STATS_EN.
- When defined, adds outputs stat_frames0 and stat_frames1 (32 bits each, wrapping). Each counts the tlast handshakes of its source.
- Also adds stat_ts_orphan (16 bits, saturating). It counts timestamps routed to a source whose sequence number is not the oldest outstanding one, tracked by a per-source expected-sequence register.
- All counters reset to 0.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header ptp_tx_arb_pkg holds:
  - the FSM state encoding (IDLE=2'd0, TAG=2'd1, XFER=2'd2);
  - the tag field positions (ID bit = PTP_TAG_WIDTH-1, SEQ = [PTP_TAG_WIDTH-2:0]).
- One natural sub-module: ptp_tx_arb_ts_demux, which holds the combinational timestamp return routing (plus the orphan check when the stats macro is defined).

Test Plan:
- Single frame, source 0 only, 3 beats 0xAA,0xBB,0xCC: tag 0x0000 is issued, m_axis carries the 3 bytes with tlast on 0xCC, then grant returns to 0, and seq0 becomes 1.
- Both sources hold tvalid from reset, 4 frames each: the grant order is 0,1,0,1,…; the tags are 0x0000, 0x8000, 0x0001, 0x8001, and so on.
- Tag back-pressure: hold tag_ready=0 for 5 cycles in TAG. m_axis_tvalid stays 0, s0_tready stays 0 and tag_valid stays 1. The first beat passes the cycle after ready rises.
- Timestamp routing: MAC returns ts=96'h1_0000_0000_0000_0123 with tag 0x8005. m1 gets the ts with tag 0x0005 and m0_valid stays 0. Hold m1_ready=0 and check s_ready=0.
- Sequence wrap with PTP_TAG_WIDTH=4: after 8 source-0 frames, the 9th tag is 0x0 again.
- Async reset mid-XFER (at beat 2 of 4): m_axis_tvalid=0 and grant=0 without waiting for a clock edge. After release, source 1 tvalid is granted with tag 0x8000 (counters cleared).
